// File: rtl/cpu_pkg.sv
// Shared constants and types for the writeback register file and its dump engine.
package cpu_pkg;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 3;
  localparam int NREG   = 2 ** ADDR_W;

  typedef enum logic {
    DUMP_IDLE,
    DUMP_RUN
  } dump_state_t;

endpackage

// File: rtl/regfile_dump_ctrl.sv
// Dump sequencer: walks register indices 0..NREG-1 over a valid/ready handshake.
module regfile_dump_ctrl
  import cpu_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              dump_req,
  input  logic              dump_ready,
  output logic              dump_valid,
  output logic              dump_busy,
  output logic [ADDR_W-1:0] dump_addr
);

  dump_state_t       state_reg;
  logic [ADDR_W-1:0] idx_reg;
  logic              valid_reg;
  logic              busy_reg;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg <= DUMP_IDLE;
      idx_reg   <= '0;
      valid_reg <= 1'b0;
      busy_reg  <= 1'b0;
    end else begin
      case (state_reg)
        DUMP_IDLE: begin
          if (dump_req) begin
            state_reg <= DUMP_RUN;
            idx_reg   <= '0;
            valid_reg <= 1'b1;
            busy_reg  <= 1'b1;
          end
        end
        DUMP_RUN: begin
          // A new request is not accepted until the last beat has gone out.
          if (dump_ready) begin
            if (idx_reg == ADDR_W'(NREG - 1)) begin
              state_reg <= DUMP_IDLE;
              idx_reg   <= '0;
              valid_reg <= 1'b0;
              busy_reg  <= 1'b0;
            end else begin
              idx_reg <= idx_reg + 1'b1;
            end
          end
        end
        default: begin
          state_reg <= DUMP_IDLE;
          idx_reg   <= '0;
          valid_reg <= 1'b0;
          busy_reg  <= 1'b0;
        end
      endcase
    end
  end

  assign dump_valid = valid_reg;
  assign dump_busy  = busy_reg;
  assign dump_addr  = idx_reg;

endmodule

// File: rtl/writeback_regfile.sv
// Writeback result select, 8x16 register file with write-first bypass on the
// two decode read ports and on the debug dump stream.
module writeback_regfile
  import cpu_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              MemToRegW,
  input  logic              RegWriteW,
  input  logic [ADDR_W-1:0] WriteRegW,
  input  logic [DATA_W-1:0] MemReadDataW,
  input  logic [DATA_W-1:0] alu_resultW,
  output logic [DATA_W-1:0] ResultW,
  input  logic [ADDR_W-1:0] ReadReg1D,
  input  logic [ADDR_W-1:0] ReadReg2D,
  output logic [DATA_W-1:0] ReadData1D,
  output logic [DATA_W-1:0] ReadData2D,
  input  logic              dump_req,
  output logic              dump_valid,
  input  logic              dump_ready,
  output logic [ADDR_W-1:0] dump_addr,
  output logic [DATA_W-1:0] dump_data,
  output logic              dump_busy
);

  localparam int NPORT = 3;

  // R0 has no storage; it is forced to zero in the read mux.
  logic [DATA_W-1:0] regs [1:NREG-1];
  logic [ADDR_W-1:0] rd_addr [NPORT];
  logic [ADDR_W-1:0] dump_idx;

  assign ResultW = MemToRegW ? MemReadDataW : alu_resultW;

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 1; i < NREG; i++) begin
        regs[i] <= '0;
      end
    end else if (RegWriteW && (WriteRegW != '0)) begin
      regs[WriteRegW] <= ResultW;
    end
  end

  regfile_dump_ctrl u_dump_ctrl (
    .clk        (clk),
    .reset      (reset),
    .dump_req   (dump_req),
    .dump_ready (dump_ready),
    .dump_valid (dump_valid),
    .dump_busy  (dump_busy),
    .dump_addr  (dump_idx)
  );

  assign rd_addr[0] = ReadReg1D;
  assign rd_addr[1] = ReadReg2D;
  assign rd_addr[2] = dump_idx;

  genvar gi;
  generate
    for (gi = 0; gi < NPORT; gi++) begin : g_rd
      logic [DATA_W-1:0] data;
      always_comb begin
        data = '0;
        if (rd_addr[gi] == '0) begin
          data = '0;
        end else if (RegWriteW && (WriteRegW == rd_addr[gi])) begin
          data = ResultW;
        end else begin
          data = regs[rd_addr[gi]];
        end
      end
    end
  endgenerate

  assign ReadData1D = g_rd[0].data;
  assign ReadData2D = g_rd[1].data;
  assign dump_addr  = dump_idx;
  assign dump_data  = g_rd[2].data;

endmodule

// File: tb/tb_writeback_regfile.sv
// Scoreboard bench: directed scenarios then random traffic, checked against an array model.
module tb_writeback_regfile;

  logic        clk;
  logic        reset;
  logic        MemToRegW;
  logic        RegWriteW;
  logic [2:0]  WriteRegW;
  logic [15:0] MemReadDataW;
  logic [15:0] alu_resultW;
  logic [15:0] ResultW;
  logic [2:0]  ReadReg1D;
  logic [2:0]  ReadReg2D;
  logic [15:0] ReadData1D;
  logic [15:0] ReadData2D;
  logic        dump_req;
  logic        dump_valid;
  logic        dump_ready;
  logic [2:0]  dump_addr;
  logic [15:0] dump_data;
  logic        dump_busy;

  int total = 0;
  int bad = 0;
  bit mon_on = 0;

  logic [15:0] mregs [8];
  int beats_left = 0;
  int exp_q [$];

  writeback_regfile dut (
    .clk          (clk),
    .reset        (reset),
    .MemToRegW    (MemToRegW),
    .RegWriteW    (RegWriteW),
    .WriteRegW    (WriteRegW),
    .MemReadDataW (MemReadDataW),
    .alu_resultW  (alu_resultW),
    .ResultW      (ResultW),
    .ReadReg1D    (ReadReg1D),
    .ReadReg2D    (ReadReg2D),
    .ReadData1D   (ReadData1D),
    .ReadData2D   (ReadData2D),
    .dump_req     (dump_req),
    .dump_valid   (dump_valid),
    .dump_ready   (dump_ready),
    .dump_addr    (dump_addr),
    .dump_data    (dump_data),
    .dump_busy    (dump_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] exp_result();
    return MemToRegW ? MemReadDataW : alu_resultW;
  endfunction

  function automatic logic [15:0] exp_read(input int a);
    if (a == 0) return 16'h0000;
    if (RegWriteW && (int'(WriteRegW) == a)) return exp_result();
    return mregs[a];
  endfunction

  task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference model: registers as a plain array, a dump as a list of 8 expected indices.
  initial begin
    for (int i = 0; i < 8; i++) mregs[i] = 16'h0000;
    forever begin
      @(posedge clk);
      if (!reset) begin
        for (int i = 0; i < 8; i++) mregs[i] = 16'h0000;
        beats_left = 0;
        exp_q.delete();
      end else begin
        if (RegWriteW && WriteRegW != 3'd0) mregs[WriteRegW] = exp_result();
        if (beats_left != 0) begin
          if (dump_ready) beats_left--;
        end else if (dump_req) begin
          beats_left = 8;
          for (int a = 0; a < 8; a++) exp_q.push_back(a);
        end
      end
    end
  end

  // Monitor: compares every cycle and pops one expected beat per handshake.
  initial begin
    forever begin
      @(negedge clk);
      if (mon_on) begin
        check("result", ResultW, exp_result());
        check("rd1", ReadData1D, exp_read(int'(ReadReg1D)));
        check("rd2", ReadData2D, exp_read(int'(ReadReg2D)));
        check("valid", 16'(dump_valid), 16'(beats_left != 0));
        check("busy", 16'(dump_busy), 16'(beats_left != 0));
        if (dump_valid && dump_ready) begin
          if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL extra_beat: got addr %0d want no beat at %0t", dump_addr, $time);
          end else begin
            int a;
            a = exp_q.pop_front();
            check("beat_addr", 16'(dump_addr), 16'(a));
            check("beat_data", dump_data, exp_read(a));
            $display("beat addr=%0d data=%h", dump_addr, dump_data);
          end
        end else if (dump_valid && exp_q.size() != 0) begin
          check("hold_addr", 16'(dump_addr), 16'(exp_q[0]));
        end
      end
    end
  end

  initial begin
    reset = 1'b0; MemToRegW = 1'b0; RegWriteW = 1'b0; WriteRegW = 3'd0;
    MemReadDataW = 16'h0; alu_resultW = 16'h0; ReadReg1D = 3'd0; ReadReg2D = 3'd0;
    dump_req = 1'b0; dump_ready = 1'b0;
    step();
    step();
    mon_on = 1'b1;
    @(negedge clk);
    check("rst_valid", 16'(dump_valid), 16'h0);
    check("rst_addr", 16'(dump_addr), 16'h0);
    check("rst_data", dump_data, 16'h0);
    reset = 1'b1;

    for (int i = 1; i < 8; i++) begin
      step();
      ReadReg1D = 3'(i); ReadReg2D = 3'(8 - i);
      @(negedge clk);
      check("rst_rd1", ReadData1D, 16'h0000);
      check("rst_rd2", ReadData2D, 16'h0000);
    end

    step();
    RegWriteW = 1'b1; WriteRegW = 3'd0; alu_resultW = 16'hFFFF; ReadReg1D = 3'd0;
    step();
    RegWriteW = 1'b0;
    @(negedge clk);
    check("r0_zero", ReadData1D, 16'h0000);

    step();
    RegWriteW = 1'b1; MemToRegW = 1'b1; WriteRegW = 3'd3;
    MemReadDataW = 16'hBEEF; alu_resultW = 16'h1234; ReadReg1D = 3'd3;
    @(negedge clk);
    check("beef_result", ResultW, 16'hBEEF);
    check("beef_bypass", ReadData1D, 16'hBEEF);
    step();
    RegWriteW = 1'b0;
    @(negedge clk);
    check("beef_array", ReadData1D, 16'hBEEF);

    step();
    RegWriteW = 1'b1; MemToRegW = 1'b0; WriteRegW = 3'd5; alu_resultW = 16'h1234;
    @(negedge clk);
    check("alu_result", ResultW, 16'h1234);
    step();
    RegWriteW = 1'b0; ReadReg2D = 3'd5;
    @(negedge clk);
    check("r5_read", ReadData2D, 16'h1234);

    // Full dump with ready held high.
    for (int n = 1; n < 8; n++) begin
      step();
      RegWriteW = 1'b1; MemToRegW = 1'b0; WriteRegW = 3'(n); alu_resultW = 16'(16'h1111 * n);
    end
    step();
    RegWriteW = 1'b0; dump_req = 1'b1; dump_ready = 1'b1;
    step();
    dump_req = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      check("full_valid", 16'(dump_valid), 16'h1);
      check("full_addr", 16'(dump_addr), 16'(k));
      check("full_data", dump_data, 16'(16'h1111 * k));
      step();
    end
    @(negedge clk);
    check("full_done_busy", 16'(dump_busy), 16'h0);
    check("full_done_valid", 16'(dump_valid), 16'h0);

    // Stall at index 2 while R2 is overwritten.
    step();
    dump_req = 1'b1; dump_ready = 1'b1;
    step();
    dump_req = 1'b0;
    step();
    step();
    dump_ready = 1'b0; RegWriteW = 1'b1; MemToRegW = 1'b0; WriteRegW = 3'd2; alu_resultW = 16'hAAAA;
    for (int s = 0; s < 3; s++) begin
      @(negedge clk);
      check("stall_addr", 16'(dump_addr), 16'h2);
      check("stall_data", dump_data, 16'hAAAA);
      step();
      RegWriteW = 1'b0;
    end
    dump_ready = 1'b1;
    @(negedge clk);
    check("stall_accept", dump_data, 16'hAAAA);
    step();
    @(negedge clk);
    check("stall_next", 16'(dump_addr), 16'h3);
    for (int k = 0; k < 5; k++) step();
    @(negedge clk);
    check("stall_done", 16'(dump_busy), 16'h0);

    // Reset in the middle of a dump.
    step();
    dump_req = 1'b1; dump_ready = 1'b1;
    step();
    dump_req = 1'b0;
    for (int k = 0; k < 4; k++) step();
    @(negedge clk);
    check("abort_at", 16'(dump_addr), 16'h4);
    step();
    reset = 1'b0; dump_ready = 1'b0;
    step();
    reset = 1'b1;
    @(negedge clk);
    check("abort_valid", 16'(dump_valid), 16'h0);
    check("abort_busy", 16'(dump_busy), 16'h0);
    for (int i = 1; i < 8; i++) begin
      step();
      ReadReg1D = 3'(i);
      @(negedge clk);
      check("abort_clear", ReadData1D, 16'h0000);
    end

    // Random traffic, checked only by the monitor.
    for (int c = 0; c < 3000; c++) begin
      step();
      reset        = ($urandom_range(0, 149) != 0);
      RegWriteW    = 1'($urandom_range(0, 1));
      MemToRegW    = 1'($urandom_range(0, 1));
      WriteRegW    = 3'($urandom_range(0, 7));
      MemReadDataW = 16'($urandom);
      alu_resultW  = 16'($urandom);
      ReadReg1D    = 3'($urandom_range(0, 7));
      ReadReg2D    = 3'($urandom_range(0, 7));
      dump_req     = ($urandom_range(0, 7) == 0);
      dump_ready   = ($urandom_range(0, 3) != 0);
    end
    step();
    @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
